// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the victim writeback reader.
package cache_pkg;

    // Writeback sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        ADDR    = 3'd2,
        DATA    = 3'd3,
        DONE    = 3'd4
    } wb_state_t;

    // Number of bits in one cache line
    function automatic int line_bits_of(input int block_size);
        return block_size * 8;
    endfunction

    // Number of writeback beats needed to move one line
    function automatic int beats_of(input int block_size, input int beat_width);
        return (block_size * 8) / beat_width;
    endfunction

    // Counter width that never collapses to zero bits
    function automatic int count_width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_way_index.sv
// Converts a one-hot way vector into a binary index and flags whether
// exactly one bit is set.
module onehot_way_index #(
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [NUM_WAYS-1:0]    onehot,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   is_onehot
);

    // OR together the positions of set bits; exact when the input is one-hot
    always_comb begin
        index = {INDEX_WIDTH{1'b0}};
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (onehot[i]) begin
                index = index | INDEX_WIDTH'(i);
            end else begin
                index = index;
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    always_comb begin
        is_onehot = (onehot != {NUM_WAYS{1'b0}}) &&
                    ((onehot & (onehot - {{(NUM_WAYS-1){1'b0}}, 1'b1})) == {NUM_WAYS{1'b0}});
    end

endmodule

// File: rtl/victim_writeback_reader.sv
// Victim writeback reader: on an eviction request, reads the targeted way
// for one cycle, buffers the line, frees the way, and if the line was
// valid and dirty streams it to the next memory level as one address
// phase followed by BEAT_WIDTH-bit data beats.
// Optional build macro VICTIM_PARITY_EN adds a wb_data_parity output
// (even-parity XOR of wb_data) that travels with each beat.
module victim_writeback_reader
    import cache_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int BEAT_WIDTH    = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          evict_valid,
    output logic                                          evict_ready,
    input  logic [NUM_WAYS-1:0]                           evict_target,
    output logic [NUM_WAYS-1:0]                           way_rEn,
    input  logic [NUM_WAYS*line_bits_of(BLOCK_SIZE)-1:0]  way_dataOut,
    input  logic [NUM_WAYS*ADDRESS_WIDTH-1:0]             way_lineAddr,
    input  logic [NUM_WAYS-1:0]                           way_valid,
    input  logic [NUM_WAYS-1:0]                           way_dirty,
    output logic                                          captured,
    output logic                                          wb_addr_valid,
    input  logic                                          wb_addr_ready,
    output logic [ADDRESS_WIDTH-1:0]                      wb_addr,
    output logic                                          wb_data_valid,
    input  logic                                          wb_data_ready,
    output logic [BEAT_WIDTH-1:0]                         wb_data,
    output logic                                          wb_last,
    output logic                                          wb_done,
    output logic                                          wb_error
`ifdef VICTIM_PARITY_EN
    ,
    output logic                                          wb_data_parity
`endif
);

    localparam int LINE_BITS   = line_bits_of(BLOCK_SIZE);
    localparam int BEATS       = beats_of(BLOCK_SIZE, BEAT_WIDTH);
    localparam int CW          = count_width_of(BEATS);
    localparam int IW          = $clog2(NUM_WAYS);
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);

    localparam logic [CW-1:0]            LAST_BEAT   = CW'(BEATS - 1);
    localparam logic                     SINGLE_BEAT = (BEATS == 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
        ADDRESS_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

`ifdef VICTIM_PARITY_EN
    // Even parity of one data beat
    function automatic logic beat_parity(input logic [BEAT_WIDTH-1:0] beat);
        return ^beat;
    endfunction
`endif

    wb_state_t                state_r;
    logic [NUM_WAYS-1:0]      target_r;
    logic [LINE_BITS-1:0]     line_buf_r;
    logic [CW-1:0]            beat_r;

    logic [NUM_WAYS-1:0]      check_vec_s;
    logic [IW-1:0]            sel_idx_s;
    logic                     sel_onehot_s;
    logic [LINE_BITS-1:0]     sel_line_s;
    logic [ADDRESS_WIDTH-1:0] sel_addr_s;
    logic                     sel_valid_s;
    logic                     sel_dirty_s;
    logic [CW-1:0]            beat_next_s;
    logic [BEAT_WIDTH-1:0]    beat_next_data_s;
    logic                     accept_s;

    // In IDLE the decoder validates the incoming request; afterwards it
    // steers the capture mux from the registered target.
    assign check_vec_s = (state_r == IDLE) ? evict_target : target_r;

    onehot_way_index #(
        .NUM_WAYS    (NUM_WAYS),
        .INDEX_WIDTH (IW)
    ) u_way_index (
        .onehot    (check_vec_s),
        .index     (sel_idx_s),
        .is_onehot (sel_onehot_s)
    );

    assign sel_line_s  = way_dataOut[sel_idx_s*LINE_BITS +: LINE_BITS];
    assign sel_addr_s  = way_lineAddr[sel_idx_s*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_valid_s = way_valid[sel_idx_s];
    assign sel_dirty_s = way_dirty[sel_idx_s];

    assign beat_next_s      = beat_r + {{(CW-1){1'b0}}, 1'b1};
    assign beat_next_data_s = line_buf_r[beat_next_s*BEAT_WIDTH +: BEAT_WIDTH];

    assign evict_ready = (state_r == IDLE) && !reset;
    assign accept_s    = evict_valid && evict_ready;
    assign way_rEn     = (state_r == CAPTURE) ? target_r : {NUM_WAYS{1'b0}};

    // Sequencer: state, beat counter, line buffer and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            target_r       <= {NUM_WAYS{1'b0}};
            line_buf_r     <= {LINE_BITS{1'b0}};
            beat_r         <= {CW{1'b0}};
            captured       <= 1'b0;
            wb_addr_valid  <= 1'b0;
            wb_addr        <= {ADDRESS_WIDTH{1'b0}};
            wb_data_valid  <= 1'b0;
            wb_data        <= {BEAT_WIDTH{1'b0}};
            wb_last        <= 1'b0;
            wb_done        <= 1'b0;
            wb_error       <= 1'b0;
`ifdef VICTIM_PARITY_EN
            wb_data_parity <= 1'b0;
`endif
        end else begin
            captured <= 1'b0;
            wb_done  <= 1'b0;
            wb_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        target_r <= evict_target;
                        if (sel_onehot_s) begin
                            state_r <= CAPTURE;
                        end else begin
                            // Malformed target: retire immediately, nothing read
                            state_r  <= DONE;
                            wb_done  <= 1'b1;
                            wb_error <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    // Way read strobe is high this cycle; take the line now
                    line_buf_r <= sel_line_s;
                    wb_addr    <= sel_addr_s & ~OFFSET_MASK;
                    captured   <= 1'b1;
                    if (sel_valid_s && sel_dirty_s) begin
                        state_r       <= ADDR;
                        wb_addr_valid <= 1'b1;
                    end else begin
                        // Clean or invalid victim needs no writeback
                        state_r <= DONE;
                        wb_done <= 1'b1;
                    end
                end
                ADDR: begin
                    if (wb_addr_ready) begin
                        state_r        <= DATA;
                        wb_addr_valid  <= 1'b0;
                        wb_data_valid  <= 1'b1;
                        wb_data        <= line_buf_r[BEAT_WIDTH-1:0];
                        wb_last        <= SINGLE_BEAT;
                        beat_r         <= {CW{1'b0}};
`ifdef VICTIM_PARITY_EN
                        wb_data_parity <= beat_parity(line_buf_r[BEAT_WIDTH-1:0]);
`endif
                    end
                end
                DATA: begin
                    if (wb_data_ready) begin
                        if (beat_r == LAST_BEAT) begin
                            state_r       <= DONE;
                            beat_r        <= {CW{1'b0}};
                            wb_data_valid <= 1'b0;
                            wb_last       <= 1'b0;
                            wb_done       <= 1'b1;
                        end else begin
                            beat_r         <= beat_next_s;
                            wb_data        <= beat_next_data_s;
                            wb_last        <= (beat_next_s == LAST_BEAT);
`ifdef VICTIM_PARITY_EN
                            wb_data_parity <= beat_parity(beat_next_data_s);
`endif
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victim_writeback_reader.sv
// Self-checking bench for victim_writeback_reader: directed table, hand
// sequences for backpressure/reset/parity, and randomized requests checked
// against a line-level reference model.
`timescale 1ns/1ps
module tb_victim_writeback_reader;

    localparam int NW = 4;
    localparam int AW = 32;
    localparam int BS = 32;
    localparam int BW = 32;
    localparam int LB = BS * 8;
    localparam int NB = LB / BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              evict_valid;
    logic              evict_ready;
    logic [NW-1:0]     evict_target;
    logic [NW-1:0]     way_rEn;
    logic [NW*LB-1:0]  way_dataOut;
    logic [NW*AW-1:0]  way_lineAddr;
    logic [NW-1:0]     way_valid;
    logic [NW-1:0]     way_dirty;
    logic              captured;
    logic              wb_addr_valid;
    logic              wb_addr_ready;
    logic [AW-1:0]     wb_addr;
    logic              wb_data_valid;
    logic              wb_data_ready;
    logic [BW-1:0]     wb_data;
    logic              wb_last;
    logic              wb_done;
    logic              wb_error;
`ifdef VICTIM_PARITY_EN
    logic              wb_data_parity;
`endif

    always #5 clk = ~clk;

    victim_writeback_reader #(
        .NUM_WAYS(NW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .BEAT_WIDTH(BW)
    ) dut (
        .clk(clk), .reset(reset),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_target(evict_target),
        .way_rEn(way_rEn), .way_dataOut(way_dataOut), .way_lineAddr(way_lineAddr),
        .way_valid(way_valid), .way_dirty(way_dirty), .captured(captured),
        .wb_addr_valid(wb_addr_valid), .wb_addr_ready(wb_addr_ready), .wb_addr(wb_addr),
        .wb_data_valid(wb_data_valid), .wb_data_ready(wb_data_ready), .wb_data(wb_data),
        .wb_last(wb_last), .wb_done(wb_done), .wb_error(wb_error)
`ifdef VICTIM_PARITY_EN
        , .wb_data_parity(wb_data_parity)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference contents of the cache ways
    logic [LB-1:0] mem_line [NW];
    logic [AW-1:0] mem_addr [NW];
    logic [NW-1:0] mem_valid;
    logic [NW-1:0] mem_dirty;

    typedef struct {
        logic [NW-1:0] target;
        logic          v;
        logic          d;
        int            mode;
        logic          exp_err;
        logic          exp_wb;
        int            exp_done;
    } vec_t;

    vec_t vecs[7];

    // Randomize every way, then pin valid/dirty of the targeted way
    task automatic load_ways(input logic [NW-1:0] target, input logic v, input logic d);
        for (int w = 0; w < NW; w++) begin
            for (int j = 0; j < LB / 32; j++) mem_line[w][j*32 +: 32] = $urandom();
            mem_addr[w]  = $urandom();
            mem_valid[w] = 1'($urandom_range(0, 1));
            mem_dirty[w] = 1'($urandom_range(0, 1));
            if (target[w]) begin
                mem_valid[w] = v;
                mem_dirty[w] = d;
            end
        end
    endtask

    // Ways present real contents only while read; otherwise garbage
    task automatic drive_ways();
        if (way_rEn != '0) begin
            for (int w = 0; w < NW; w++) begin
                way_dataOut[w*LB +: LB]  = mem_line[w];
                way_lineAddr[w*AW +: AW] = mem_addr[w];
            end
            way_valid = mem_valid;
            way_dirty = mem_dirty;
        end else begin
            for (int j = 0; j < NW * LB / 32; j++) way_dataOut[j*32 +: 32] = $urandom();
            for (int w = 0; w < NW; w++) way_lineAddr[w*AW +: AW] = $urandom();
            way_valid = 4'($urandom());
            way_dirty = 4'($urandom());
        end
    endtask

    // mode 0: always ready; 1: pattern 1,0,0,1; 2: random
    task automatic set_ready(input int mode, input int t);
        if (mode == 0) begin
            wb_addr_ready = 1'b1;
            wb_data_ready = 1'b1;
        end else if (mode == 1) begin
            wb_addr_ready = ((t % 4) == 0) || ((t % 4) == 3);
            wb_data_ready = wb_addr_ready;
        end else begin
            wb_addr_ready = 1'($urandom_range(0, 1));
            wb_data_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // One full request; called and returns at #1 after a rising edge with the DUT idle
    task automatic run_request(input logic [NW-1:0] target, input int mode, input logic exp_err,
                               input logic exp_wb, input int exp_done, input string tag);
        int t = 0, done_t = -1, ren_cnt = 0, ren_t = -1, cap_cnt = 0, cap_t = -1;
        int addr_cnt = 0, first_addr_t = -1, stall_viol = 0, ready_viol = 0, pulse_viol = 0;
        int w = 0;
        logic [NW-1:0] ren_seen = '0;
        logic [AW-1:0] addr_seen = '0;
        logic err_seen = 1'b0;
        logic a_stall = 1'b0, d_stall = 1'b0, st_last = 1'b0;
        logic [AW-1:0] st_addr = '0;
        logic [BW-1:0] st_data = '0;
        logic [BW-1:0] beats_q[$];
        logic          last_q[$];
`ifdef VICTIM_PARITY_EN
        logic          par_q[$];
`endif
        for (int i = 0; i < NW; i++) if (target[i]) w = i;

        evict_target = target;
        evict_valid  = 1'b1;
        chk({tag, "_accept_ready"}, evict_ready, 1);
        set_ready(mode, 0);
        drive_ways();
        while (done_t < 0 && t < 200) begin
            @(posedge clk); #1; t++;
            if (evict_ready) ready_viol++;
            if (way_rEn != '0) begin ren_cnt++; ren_seen = way_rEn; ren_t = t; end
            if (captured) begin cap_cnt++; cap_t = t; end
            if (a_stall && (!wb_addr_valid || wb_addr !== st_addr)) stall_viol++;
            if (d_stall && (!wb_data_valid || wb_data !== st_data || wb_last !== st_last)) stall_viol++;
            if (wb_addr_valid && first_addr_t < 0) first_addr_t = t;
            set_ready(mode, t);
            a_stall = wb_addr_valid && !wb_addr_ready;
            st_addr = wb_addr;
            d_stall = wb_data_valid && !wb_data_ready;
            st_data = wb_data;
            st_last = wb_last;
            if (wb_addr_valid && wb_addr_ready) begin addr_cnt++; addr_seen = wb_addr; end
            if (wb_data_valid && wb_data_ready) begin
                beats_q.push_back(wb_data);
                last_q.push_back(wb_last);
`ifdef VICTIM_PARITY_EN
                par_q.push_back(wb_data_parity);
`endif
            end
            if (wb_done) begin done_t = t; err_seen = wb_error; end
            else if (wb_error) pulse_viol++;
            drive_ways();
        end
        chk({tag, "_done_seen"}, done_t >= 0, 1);
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, evict_ready, 1);
        chk({tag, "_done_width"}, wb_done, 0);
        evict_valid = 1'b0;
        drive_ways();

        if (exp_done > 0) chk({tag, "_done_cycle"}, done_t, exp_done);
        chk({tag, "_error"}, err_seen, exp_err);
        chk({tag, "_ren_count"}, ren_cnt, exp_err ? 0 : 1);
        chk({tag, "_captured_count"}, cap_cnt, exp_err ? 0 : 1);
        if (!exp_err) begin
            chk({tag, "_ren_value"}, ren_seen, target);
            chk({tag, "_ren_cycle"}, ren_t, 1);
            chk({tag, "_captured_cycle"}, cap_t, 2);
        end
        chk({tag, "_addr_handshakes"}, addr_cnt, exp_wb ? 1 : 0);
        if (exp_wb) begin
            chk({tag, "_addr"}, addr_seen, (mem_addr[w] / BS) * BS);
            if (mode == 0) chk({tag, "_addr_cycle"}, first_addr_t, 2);
        end
        chk({tag, "_beat_count"}, beats_q.size(), exp_wb ? NB : 0);
        if (exp_wb && beats_q.size() == NB) begin
            for (int k = 0; k < NB; k++) begin
                logic [LB-1:0] sh;
                sh = mem_line[w] >> (k * BW);
                chk($sformatf("%s_beat%0d", tag, k), beats_q[k], sh[BW-1:0]);
                chk($sformatf("%s_last%0d", tag, k), last_q[k], k == NB - 1);
`ifdef VICTIM_PARITY_EN
                chk($sformatf("%s_parity%0d", tag, k), par_q[k], ^sh[BW-1:0]);
`endif
            end
        end
        chk({tag, "_stall_stability"}, stall_viol, 0);
        chk({tag, "_busy_not_ready"}, ready_viol, 0);
        chk({tag, "_error_without_done"}, pulse_viol, 0);
    endtask

    initial begin
        int hs;
        logic [LB-1:0] sh;
        reset = 1'b1;
        evict_valid = 1'b0;
        evict_target = '0;
        wb_addr_ready = 1'b0;
        wb_data_ready = 1'b0;
        way_dataOut = '0; way_lineAddr = '0; way_valid = '0; way_dirty = '0;

        vecs[0] = '{4'b0100, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3 + NB};
        vecs[1] = '{4'b0001, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2};
        vecs[2] = '{4'b0110, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1};
        vecs[3] = '{4'b0000, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1};
        vecs[4] = '{4'b1000, 1'b0, 1'b1, 0, 1'b0, 1'b0, 2};
        vecs[5] = '{4'b0010, 1'b1, 1'b1, 1, 1'b0, 1'b1, -1};
        vecs[6] = '{4'b0001, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3 + NB};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evict_ready", evict_ready, 0);
        chk("rst_way_rEn", way_rEn, 0);
        chk("rst_captured", captured, 0);
        chk("rst_addr_valid", wb_addr_valid, 0);
        chk("rst_data_valid", wb_data_valid, 0);
        chk("rst_last", wb_last, 0);
        chk("rst_done", wb_done, 0);
        chk("rst_error", wb_error, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            load_ways(vecs[i].target, vecs[i].v, vecs[i].d);
            run_request(vecs[i].target, vecs[i].mode, vecs[i].exp_err, vecs[i].exp_wb,
                        vecs[i].exp_done, $sformatf("vec%0d", i));
        end

        // Known beat values 7 and 3 (parity 1 and 0)
        load_ways(4'b0100, 1'b1, 1'b1);
        mem_line[2][31:0]  = 32'h0000_0007;
        mem_line[2][63:32] = 32'h0000_0003;
        run_request(4'b0100, 0, 1'b0, 1'b1, 3 + NB, "parity_beats");

        // Reset while beat 3 is presented
        load_ways(4'b0100, 1'b1, 1'b1);
        evict_target = 4'b0100;
        evict_valid = 1'b1;
        wb_addr_ready = 1'b1;
        wb_data_ready = 1'b1;
        drive_ways();
        hs = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            evict_valid = 1'b0;
            drive_ways();
            if (wb_data_valid) begin
                if (hs == 3) break;
                hs++;
            end
        end
        sh = mem_line[2] >> (3 * BW);
        chk("midrst_beat3", wb_data, sh[BW-1:0]);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_data_valid", wb_data_valid, 0);
        chk("midrst_addr_valid", wb_addr_valid, 0);
        chk("midrst_last", wb_last, 0);
        chk("midrst_done", wb_done, 0);
        chk("midrst_error", wb_error, 0);
        chk("midrst_ready_in_reset", evict_ready, 0);
        chk("midrst_ren", way_rEn, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_done_after", wb_done, 0);
        chk("midrst_ready_after", evict_ready, 1);
        drive_ways();
        load_ways(4'b1000, 1'b1, 1'b1);
        run_request(4'b1000, 0, 1'b0, 1'b1, 3 + NB, "post_reset");

        // Randomized requests against the reference rules
        for (int r = 0; r < 24; r++) begin
            logic [NW-1:0] tgt;
            int mode, w, edone;
            logic e_err, e_wb;
            if ($urandom_range(0, 6) == 0) tgt = 4'($urandom());
            else tgt = 4'(1 << $urandom_range(0, NW - 1));
            load_ways(tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            mode = $urandom_range(0, 1) * 2;
            w = 0;
            for (int i = 0; i < NW; i++) if (tgt[i]) w = i;
            e_err = ($countones(tgt) != 1);
            e_wb  = !e_err && mem_valid[w] && mem_dirty[w];
            if (mode != 0) edone = -1;
            else if (e_err) edone = 1;
            else if (e_wb) edone = 3 + NB;
            else edone = 2;
            run_request(tgt, mode, e_err, e_wb, edone, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
